// File: rtl/ysyx_040978_mul_iter.sv
// ysyx_040978_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle, 128-bit product
module ysyx_040978_mul_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mulw,
    input  logic [1:0]  mul_signed,
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    output logic        out_valid,
    output logic [63:0] result_hi,
    output logic [63:0] result_lo
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    logic [63:0]  a_reg;
    logic [63:0]  b_reg;
    logic [127:0] acc;
    logic [6:0]   i;
    logic         neg;
    logic         mulw_reg;

    logic         accept;
    logic         last;
    logic         sign_a;
    logic         sign_b;
    logic [63:0]  abs_a;
    logic [63:0]  abs_b;
    logic [127:0] product;

    assign in_ready  = (state == IDLE) || (state == DONE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready & ~flush;
    assign last      = i == (mulw_reg ? 7'd31 : 7'd63);

    // Operand sign/magnitude decode; the multiplier is only signed for MULH (01 behaves as 00)
    always_comb begin
        sign_a  = ~mulw & mul_signed[1] & multiplicand[63];
        sign_b  = ~mulw & (&mul_signed) & multiplier[63];
        abs_a   = mulw ? {32'b0, multiplicand[31:0]} : (sign_a ? -multiplicand : multiplicand);
        abs_b   = mulw ? {32'b0, multiplier[31:0]} : (sign_b ? -multiplier : multiplier);
        product = neg ? (~acc + 128'd1) : acc;
    end

    // Outputs are zero outside the DONE cycle; W-form returns the sign-extended low word
    always_comb begin
        result_hi = (out_valid && !mulw_reg) ? product[127:64] : 64'b0;
        result_lo = !out_valid ? 64'b0 : (mulw_reg ? {{32{acc[31]}}, acc[31:0]} : product[63:0]);
    end

    // Control FSM and datapath: load on accept, one shift-add step per BUSY cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            i        <= 7'd0;
            acc      <= 128'b0;
            a_reg    <= 64'b0;
            b_reg    <= 64'b0;
            neg      <= 1'b0;
            mulw_reg <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            i     <= 7'd0;
        end else if (state == BUSY) begin
            if (b_reg[0])
                acc <= acc + ({64'b0, a_reg} << i);
            b_reg <= b_reg >> 1;
            i     <= i + 7'd1;
            if (last)
                state <= DONE;
        end else if (accept) begin
            state    <= BUSY;
            i        <= 7'd0;
            acc      <= 128'b0;
            a_reg    <= abs_a;
            b_reg    <= abs_b;
            neg      <= sign_a ^ sign_b;
            mulw_reg <= mulw;
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_ysyx_040978_mul_iter.sv
// tb_ysyx_040978_mul_iter: directed and random checks of the iterative multiplier against an arithmetic model
module tb_ysyx_040978_mul_iter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mulw = 1'b0;
    logic [1:0]  mul_signed = 2'b00;
    logic [63:0] multiplicand = 64'b0;
    logic [63:0] multiplier = 64'b0;
    logic        out_valid;
    logic [63:0] result_hi;
    logic [63:0] result_lo;

    int checks = 0;
    int errors = 0;

    ysyx_040978_mul_iter dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mulw(mulw), .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
        .out_valid(out_valid), .result_hi(result_hi), .result_lo(result_lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference product from plain wide multiplication of the extended operands
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b, input logic w, input logic [1:0] ms);
        logic [127:0] ea;
        logic [127:0] eb;
        logic [63:0]  p32;
        if (w) begin
            p32 = {32'b0, a[31:0]} * {32'b0, b[31:0]};
            return {64'b0, {32{p32[31]}}, p32[31:0]};
        end
        ea = (ms[1] && a[63]) ? {{64{1'b1}}, a} : {64'b0, a};
        eb = (ms == 2'b11 && b[63]) ? {{64{1'b1}}, b} : {64'b0, b};
        return ea * eb;
    endfunction

    // Present a request at the current negedge; scramble operands right after the accept edge
    task automatic start(input logic [63:0] a, input logic [63:0] b, input logic w, input logic [1:0] ms);
        multiplicand = a;
        multiplier   = b;
        mulw         = w;
        mul_signed   = ms;
        in_valid     = 1'b1;
        chk("ready_at_accept", {127'b0, in_ready}, 128'd1);
        @(posedge clock);
        #1;
        in_valid     = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
        mulw         = 1'($urandom);
        mul_signed   = 2'($urandom);
    endtask

    // Wait for the result pulse; leaves the caller at the negedge of the DONE cycle
    task automatic wait_done(input logic w, input logic [127:0] exp, input string tag, input logic poke);
        int k = 0;
        int rdy = 0;
        int nz = 0;
        do begin
            @(negedge clock);
            k++;
            if (!out_valid && in_ready) rdy++;
            if (!out_valid && (result_hi != 0 || result_lo != 0)) nz++;
            if (poke && k == 30) begin
                multiplicand = {$urandom, $urandom};
                multiplier   = {$urandom, $urandom};
                in_valid     = 1'b1;
            end
            if (poke && k == 31) in_valid = 1'b0;
        end while (!out_valid && k < 200);
        chk({tag, "_latency"}, 128'(k), w ? 128'd33 : 128'd65);
        chk({tag, "_ready_busy"}, 128'(rdy), 128'd0);
        chk({tag, "_zero_busy"}, 128'(nz), 128'd0);
        chk({tag, "_result"}, {result_hi, result_lo}, exp);
        chk({tag, "_ready_done"}, {127'b0, in_ready}, 128'd1);
    endtask

    task automatic pulse_end(input string tag);
        @(negedge clock);
        chk({tag, "_pulse_end"}, {127'b0, out_valid}, 128'd0);
        chk({tag, "_zero_idle"}, {result_hi, result_lo}, 128'd0);
    endtask

    task automatic quiet(input string tag, input int n);
        int hits = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            if (out_valid) hits++;
        end
        chk({tag, "_no_out_valid"}, 128'(hits), 128'd0);
    endtask

    task automatic run(input logic [63:0] a, input logic [63:0] b, input logic w, input logic [1:0] ms, input logic [127:0] exp, input string tag);
        start(a, b, w, ms);
        wait_done(w, exp, tag, 1'b0);
        pulse_end(tag);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        quiet("reset_idle", 4);
        chk("reset_ready", {127'b0, in_ready}, 128'd1);
        chk("reset_results", {result_hi, result_lo}, 128'd0);

        run(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 2'b00, {64'h1, 64'hFFFF_FFFF_FFFF_FFFE}, "mulhu");
        run(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b0, 2'b11, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB}, "mulh_neg");
        run(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 2'b11, {64'h4000_0000_0000_0000, 64'h0}, "mulh_min");
        run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b10, {64'hFFFF_FFFF_FFFF_FFFF, 64'h1}, "mulhsu");
        run(64'hDEAD_0000_7FFF_FFFF, 64'h1234_0000_0000_0002, 1'b1, 2'b11, {64'h0, 64'hFFFF_FFFF_FFFF_FFFE}, "mulw");

        start(64'd9, 64'd11, 1'b0, 2'b00);
        wait_done(1'b0, 128'd99, "b2b_first", 1'b0);
        start(64'd3, 64'd5, 1'b0, 2'b00);
        wait_done(1'b0, 128'd15, "b2b_second", 1'b1);
        pulse_end("b2b_second");
        quiet("b2b_ignored", 70);

        start({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 2'b11);
        repeat (9) @(negedge clock);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clock);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_ready", {127'b0, in_ready}, 128'd1);
        quiet("flush", 70);
        run(64'd6, 64'd7, 1'b0, 2'b00, 128'd42, "after_flush");

        start({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 2'b10);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_ready", {127'b0, in_ready}, 128'd1);
        quiet("rst", 70);
        run(64'd6, 64'd7, 1'b1, 2'b00, 128'd42, "after_rst");

        for (int n = 0; n < 24; n++) begin
            logic [63:0] a;
            logic [63:0] b;
            logic        w;
            logic [1:0]  ms;
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            w  = ($urandom_range(0, 3) == 0);
            ms = 2'($urandom);
            if (n % 6 == 1) a = 64'h8000_0000_0000_0000;
            if (n % 6 == 2) b = 64'h0;
            run(a, b, w, ms, model(a, b, w, ms), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_040978_mul_iter.md
# ysyx_040978_mul_iter

Iterative shift-add integer multiplier for the RV64M execute stage. It accepts one request at a time over an in_valid/in_ready handshake and retires one multiplier bit per cycle: 64 iterations for 64-bit ops, 32 for the W-form. It returns the full 128-bit product as hi/lo halves under a one-cycle out_valid pulse. It is the companion of the iterative divider and uses the same request/response discipline, so the EXU drives both units identically.

## Interface
- No parameters. Width is fixed at 64 bits.
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clock
- flush  in  1  synchronous kill; drops any in-flight or same-cycle request
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- mulw  in  1  1 = 32-bit W-form (MULW)
- mul_signed  in  2  [1] = multiplicand signed, [0] = multiplier signed; 11 = MULH, 10 = MULHSU, 00 = MULHU; 01 is treated as 00
- multiplicand  in  64  operand A
- multiplier  in  64  operand B
- out_valid  out  1  result valid, exactly one cycle per accepted request
- result_hi  out  64  product[127:64]; 0 when out_valid = 0
- result_lo  out  64  product[63:0]; 0 when out_valid = 0

## Operation
- States: IDLE, BUSY, DONE.
- in_ready = (state == IDLE) || (state == DONE).
- Accept condition: in_valid & in_ready & ~flush.
- On accept, register:
  - |A| and |B|. An operand is negated only if its sign bit is set and its mul_signed bit is 1. |0x8000_0000_0000_0000| = 2^63 as unsigned.
  - neg = signA ^ signB.
  - mulw flag.
  - iteration count: 64, or 32 when mulw.
- W-form:
  - uses A[31:0] and B[31:0] only, unsigned, with mul_signed ignored.
  - count = 32.
- BUSY, each cycle:
  - if B_reg[0]: acc[127:0] += A_reg << i, where i is the iteration index.
  - B_reg >>= 1; i += 1.
  - after the last iteration, go to DONE.
- DONE:
  - out_valid = 1.
  - product = neg ? (~acc + 1) : acc, in 128 bits.
  - 64-bit op: result_hi = product[127:64], result_lo = product[63:0].
  - W-form: result_lo = sign-extend(acc[31:0]) to 64 bits; result_hi = 0.
  - next state is BUSY if a new request is accepted in this cycle, otherwise IDLE.
- IDLE: acc, i and the operand registers hold their values; outputs are 0.
- Flush / reset:
  - next state is IDLE and i = 0.
  - out_valid is not raised for the killed operation.
  - flush beats in_valid in the same cycle.
  - reset beats flush.
- Result outputs are forced to 0 whenever out_valid = 0.

## Timing
- Reset values: in_ready = 1, out_valid = 0, result_hi = 0, result_lo = 0, state = IDLE.
- Accept at rising edge E0, then 64-bit op:
  - iterations occur at edges E1..E64.
  - out_valid is high in the cycle after E64: latency 65 cycles from accept to result.
- Accept at E0, W-form: out_valid is high in the cycle after E32 (latency 33).
- out_valid is a single-cycle pulse. There is no output backpressure; the consumer must take the result that cycle.
- Back-to-back: a request presented while in DONE is accepted at that edge. Throughput is then one op per 65 cycles (33 for W).
- in_ready is low for the whole of BUSY. in_valid during BUSY is ignored and the request is not queued.
- Operand inputs are sampled only at the accept edge and may change afterwards.
- Flush asserted in any BUSY cycle: the next cycle is IDLE with in_ready = 1, and out_valid stays 0 for the killed op.
- Flush in DONE: out_valid is still high that cycle, since it is already committed; any same-cycle request is dropped.

## Test plan
- After reset, with no requests: in_ready = 1 and out_valid/results = 0. Then MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 → hi = 0x1, lo = 0xFFFF_FFFF_FFFF_FFFE, out_valid exactly 65 cycles after accept and high for one cycle.
- MULH: -3 (0xFFFF_FFFF_FFFF_FFFD) × 7 → hi = 0xFFFF_FFFF_FFFF_FFFF, lo = 0xFFFF_FFFF_FFFF_FFEB. Then MULH 0x8000_0000_0000_0000 × 0x8000_0000_0000_0000 → hi = 0x4000_0000_0000_0000, lo = 0.
- MULHSU: 0xFFFF_FFFF_FFFF_FFFF (value -1) × 0xFFFF_FFFF_FFFF_FFFF (unsigned) → hi = 0xFFFF_FFFF_FFFF_FFFF, lo = 0x1.
- MULW: 0xDEAD_0000_7FFF_FFFF × 0x1234_0000_0000_0002 → lo = 0xFFFF_FFFF_FFFF_FFFE, hi = 0, out_valid 33 cycles after accept.
- Back-to-back:
  - request 3 × 5 while DONE of the previous op → accepted at that edge; in_ready is low for the next 64 cycles; then lo = 15.
  - in_valid pulsed mid-BUSY is ignored, with no extra out_valid.
- Flush together with a new in_valid at BUSY cycle 10 → no out_valid for either op, in_ready = 1 next cycle. Then 6 × 7 → lo = 42.
- Reset asserted at BUSY cycle 20 → same IDLE recovery as flush.
